// File: rtl/sha2_pkg.sv
// Shared SHA-2 schedule constants: sigma rotation/shift sets, round counts
// and width-generic rotate/shift helpers.
package sha2_pkg;

    typedef struct packed {
        int r0a;
        int r0b;
        int s0;
        int r1a;
        int r1b;
        int s1;
    } sigma_cfg_t;

    localparam sigma_cfg_t SIGMA_256 = '{r0a: 7, r0b: 18, s0: 3, r1a: 17, r1b: 19, s1: 10};
    localparam sigma_cfg_t SIGMA_512 = '{r0a: 1, r0b: 8,  s0: 7, r1a: 19, r1b: 61, s1: 6};

    typedef enum logic {
        PH_LOAD   = 1'b0,
        PH_EXPAND = 1'b1
    } phase_t;

    function automatic sigma_cfg_t sigma_cfg(input int word_w);
        return (word_w == 64) ? SIGMA_512 : SIGMA_256;
    endfunction

    function automatic int ROUNDS_OF(input int word_w);
        return (word_w == 64) ? 80 : 64;
    endfunction

    function automatic logic [63:0] width_mask(input int width);
        return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

    // Operands live in the low `width` bits of a 64-bit container.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int width);
        logic [63:0] m;
        logic [63:0] v;
        m = width_mask(width);
        v = x & m;
        return ((v >> n) | (v << (width - n))) & m;
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int n, input int width);
        return (x & width_mask(width)) >> n;
    endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational small-sigma function; SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter bit SEL    = 1'b0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam sigma_cfg_t CFG = sigma_cfg(WORD_W);
    localparam int RA = SEL ? CFG.r1a : CFG.r0a;
    localparam int RB = SEL ? CFG.r1b : CFG.r0b;
    localparam int SH = SEL ? CFG.s1  : CFG.s0;

    logic [63:0] x_ext;

    assign x_ext = 64'(x);
    assign y     = WORD_W'(rotr(x_ext, RA, WORD_W) ^ rotr(x_ext, RB, WORD_W) ^ shr(x_ext, SH, WORD_W));

endmodule

// File: rtl/sha2_w_sched.sv
// SHA-2 message schedule: passes the 16 block words straight through, then
// expands W_16..W_{ROUNDS-1} from a 16-deep window, one word per handshake.
module sha2_w_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_t,
    output logic              w_first,
    output logic              w_last
);

    localparam int         ROUNDS = ROUNDS_OF(WORD_W);
    localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_w_sched: WORD_W must be 32 or 64");
    end

    logic [WORD_W-1:0] win_reg [1:16];
    logic [6:0]        t_reg;
    phase_t            phase;
    logic [WORD_W-1:0] sig0;
    logic [WORD_W-1:0] sig1;
    logic [WORD_W-1:0] w_gen;
    logic              handshake;
    logic              shift_en;

    assign phase = (t_reg < 7'd16) ? PH_LOAD : PH_EXPAND;

    sha2_sigma #(.WORD_W(WORD_W), .SEL(1'b0)) u_sigma0 (
        .x (win_reg[15]),
        .y (sig0)
    );

    sha2_sigma #(.WORD_W(WORD_W), .SEL(1'b1)) u_sigma1 (
        .x (win_reg[2]),
        .y (sig1)
    );

    assign w_gen = sig1 + win_reg[7] + sig0 + win_reg[16];

    always_comb begin
        in_ready = 1'b0;
        w_valid  = 1'b1;
        w_data   = w_gen;
        if (phase == PH_LOAD) begin
            in_ready = w_ready;
            w_valid  = in_valid;
            w_data   = in_data;
        end
    end

    assign handshake = w_valid && w_ready;
    // A handshake coinciding with abort is dropped entirely.
    assign shift_en  = handshake && !abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_reg <= '0;
        end else if (abort) begin
            t_reg <= '0;
        end else if (handshake) begin
            t_reg <= (t_reg == T_LAST) ? 7'd0 : t_reg + 7'd1;
        end
    end

    // win_reg[1] is the newest word; it is loaded with whatever is emitted.
    for (genvar gi = 1; gi <= 16; gi++) begin : g_win
        if (gi == 1) begin : g_head
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    win_reg[gi] <= '0;
                end else if (shift_en) begin
                    win_reg[gi] <= w_data;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    win_reg[gi] <= '0;
                end else if (shift_en) begin
                    win_reg[gi] <= win_reg[gi-1];
                end
            end
        end
    end

    assign w_t     = t_reg;
    assign w_first = (t_reg == 7'd0);
    assign w_last  = (t_reg == T_LAST);

endmodule

// File: doc/sha2_w_sched.md
# sha2_w_sched

Parametrised SHA-2 message-schedule generator for SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).
- Accepts the 16 message words of a block over a valid/ready stream and emits W_0..W_{R-1} one per handshake, with an internal round counter.
- Sits between the block loader and the compression round datapath and replaces the externally sequenced, stall-free schedule.
- Downstream backpressure is supported, and so is an abort that discards a partially processed block.

## Interface
- WORD_W, 32: word width; legal values 32 (SHA-256) and 64 (SHA-512); any other value is an elaboration error.
- ROUNDS, derived, 64 when WORD_W=32 and 80 when WORD_W=64; not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous; discards the current block.
- in_valid  in  1  message word valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  WORD_W  message word, big-endian word order, word 0 first.
- w_valid  out  1  schedule word valid.
- w_ready  in  1  consumer accepts when w_valid && w_ready.
- w_data  out  WORD_W  W_t.
- w_t  out  7  round index t of w_data.
- w_first  out  1  asserted when t==0.
- w_last  out  1  asserted when t==ROUNDS-1.

## Operation
- State: a 16-entry window win[1..16] (win[1] newest) and a round counter t (7 bits, range 0..ROUNDS-1).
- Phase LOAD (t<16):
  - in_ready = w_ready, w_valid = in_valid, w_data = in_data; this is a zero-latency pass-through.
  - On handshake: shift the window (win[i+1]<=win[i]), win[1]<=in_data, t<=t+1.
- Phase EXPAND (t>=16):
  - in_ready=0 and w_valid=1.
  - w_data = W_gen = σ1(win[2]) + win[7] + σ0(win[15]) + win[16], computed mod 2^WORD_W.
  - On handshake: shift the window, win[1]<=W_gen, t<=t+1.
- Sigma functions:
  - SHA-256: σ0 = rotr7^rotr18^shr3; σ1 = rotr17^rotr19^shr10.
  - SHA-512: σ0 = rotr1^rotr8^shr7; σ1 = rotr19^rotr61^shr6.
- Wrap-around: a handshake at t==ROUNDS-1 sets t<=0, which returns the block to LOAD. The next block may start on the following cycle, giving no bubble between blocks.
- No handshake means no state change. In EXPAND, W_gen therefore stays stable while w_ready=0.
- abort:
  - Sets t<=0 and leaves the window contents unchanged (they are overwritten by the next load).
  - abort takes priority over a simultaneous handshake: no shift occurs, and the transfer is treated as not having happened. The consumer must drop it.
- Reset: t=0 and every window entry is 0.
  - Outputs under reset: in_ready=w_ready, w_valid=in_valid, w_t=0, w_first=1, w_last=0.
  - Reset mid-block behaves like abort, but asynchronously.

## Timing
- LOAD:
  - Combinational paths in_data→w_data, in_valid→w_valid, and w_ready→in_ready.
  - The consumer must not make w_ready depend on w_valid.
- EXPAND: W_gen is a single-cycle adder chain from registered state only. Throughput is one word per clock.
- Block latency is ROUNDS handshakes, i.e. ROUNDS cycles with no stalls: 64 for SHA-256 and 80 for SHA-512.
- w_t, w_first and w_last are decoded from the registered t. They are valid in every cycle, including stall cycles.

## Structure
- Package sha2_pkg holds:
  - the sigma rotation/shift constant sets per WORD_W;
  - ROUNDS_OF(WORD_W);
  - rotr/shr functions, parametrised by width, which replace the macros.
- Sub-module sha2_sigma (parameters WORD_W and SEL, where SEL selects σ0 or σ1) is purely combinational and is instantiated twice.
- The window is a shift register. No memory macro is used.

## Test plan
- SHA-256 "abc" block:
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1.
  - Required response: w_data at t=16 is 0x61626380 and at t=17 is 0x000F0000.
  - All 64 words must match the reference model, with w_last at t=63, followed by w_first on the next block.
- SHA-512 "abc" block:
  - Stimulus: W0=0x6162638000000000, W15=0x18.
  - Required response: t=16 gives 0x6162638000000000, and all 80 words match the model.
- Random w_ready backpressure (50%) in both phases:
  - The output sequence must be identical to the no-stall run.
  - w_data, w_t and w_valid must stay stable while stalled.
- Abort:
  - Abort at t=5 and at t=40, including a case where abort and handshake occur in the same cycle.
  - Required response: w_t=0 on the next cycle, and the next block's schedule is correct.
- Async reset:
  - Assert resetn low mid-EXPAND (t=30), between clock edges.
  - Required response: w_t=0 immediately; after release, a fresh block produces correct output.
- Back-to-back:
  - Stream three blocks with in_valid held high.
  - Required response: no idle cycles between blocks, and every word matches the model.
